// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl
//   BIST harness for the combinational ISCAS-style benchmark blocks.
//   A 60-bit Fibonacci LFSR (x^60+x^59+1) supplies one pattern per cycle to
//   the benchmark. The benchmark's response is folded into a 26-bit MISR
//   (x^26+x^6+x^2+x+1). After PAT_CNT patterns the MISR is compared with an
//   externally supplied golden signature.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        run request, sampled only in IDLE
//   seed_i         LFSR seed, captured on an accepted start (0 is mapped to 1)
//   golden_sig_i   expected signature, sampled in the CMP cycle
//   dut_in_o       pattern to the benchmark (0 outside RUN)
//   dut_out_i      benchmark response, combinational from dut_in_o
//   busy_o         high in RUN and CMP
//   done_o         one-cycle pulse in CMP
//   pass_o         compare result, held until the next accepted start
//   signature_o    live MISR contents
module bench_bist_ctrl #(
    parameter int IN_W    = 60,
    parameter int OUT_W   = 26,
    parameter int PAT_CNT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [IN_W-1:0]  seed_i,
    input  logic [OUT_W-1:0] golden_sig_i,
    output logic [IN_W-1:0]  dut_in_o,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [OUT_W-1:0] signature_o
);

    localparam int CW = $clog2(PAT_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(PAT_CNT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  lfsr_q,  lfsr_d;
    logic [OUT_W-1:0] misr_q,  misr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             pass_q,  pass_d;
    logic             misr_fb;

    assign misr_fb = misr_q[OUT_W-1] ^ misr_q[5] ^ misr_q[1] ^ misr_q[0];

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // an all-zero seed would lock the LFSR at zero
                    lfsr_d  = (seed_i == '0) ? IN_W'(1) : seed_i;
                    misr_d  = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                misr_d = {misr_q[OUT_W-2:0], misr_fb} ^ dut_out_i;
                lfsr_d = {lfsr_q[IN_W-2:0], lfsr_q[IN_W-1] ^ lfsr_q[IN_W-2]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                pass_d  = (misr_q == golden_sig_i);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // pattern bus is forced to zero outside RUN so the benchmark sees a
    // quiet input whenever no capture is taking place
    assign dut_in_o    = (state_q == S_RUN) ? lfsr_q : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_CMP);
    assign pass_o      = pass_q;
    assign signature_o = misr_q;

endmodule

// File: tb/tb_bench_bist_ctrl.sv
module tb_bench_bist_ctrl;

    localparam int IN_W  = 60;
    localparam int OUT_W = 26;
    localparam int NPAT  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [IN_W-1:0]  seed;
    logic [OUT_W-1:0] golden;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy, done, pass;
    logic [OUT_W-1:0] sig;

    // response source: 0 = tied low, 1 = manual value, 2 = stand-in benchmark,
    // 3 = stand-in benchmark with out[5] inverted (modified netlist)
    int               mode;
    logic [OUT_W-1:0] man;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] bench_f(input logic [IN_W-1:0] x);
        return x[25:0] ^ x[51:26] ^ {18'b0, x[59:52]};
    endfunction

    always_comb begin
        case (mode)
            1:       dut_out = man;
            2:       dut_out = bench_f(dut_in);
            3:       dut_out = bench_f(dut_in) ^ 26'h20;
            default: dut_out = '0;
        endcase
    end

    bench_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .PAT_CNT(NPAT)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .seed_i      (seed),
        .golden_sig_i(golden),
        .dut_in_o    (dut_in),
        .dut_out_i   (dut_out),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .signature_o (sig)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start is seen at the next edge; returns inside the first RUN cycle
    task automatic launch(input logic [IN_W-1:0] s, input logic [OUT_W-1:0] g);
        seed   = s;
        golden = g;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    logic [IN_W-1:0]  ml;
    logic [OUT_W-1:0] mm;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        seed   = '0;
        golden = '0;
        mode   = 0;
        man    = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_sig", sig, 0);
        chk("rst_dutin", dut_in, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_dutin", dut_in, 0);

        // zero response, seed 1, golden 0
        launch(60'h1, 26'h0);
        chk("z_busy", busy, 1);
        for (int i = 0; i < NPAT; i++) begin
            chk($sformatf("z_dutin%0d", i), dut_in, 64'h1 << i);
            chk($sformatf("z_done%0d", i), done, 0);
            tick();
        end
        chk("z_done", done, 1);
        chk("z_cmp_busy", busy, 1);
        chk("z_cmp_dutin", dut_in, 0);
        chk("z_sig", sig, 0);
        tick();
        chk("z_pass", pass, 1);
        chk("z_idle_done", done, 0);
        chk("z_idle_busy", busy, 0);

        // back-to-back, golden 1 -> fail; pass cleared on accepted start
        launch(60'h1, 26'h1);
        chk("z1_pass_cleared", pass, 0);
        repeat (NPAT) tick();
        chk("z1_done", done, 1);
        tick();
        chk("z1_pass", pass, 0);

        // single-cycle response on the first pattern
        mode = 1;
        man  = 26'h1;
        launch(60'h1, 26'hD);
        tick();
        man = '0;
        chk("s_sig1", sig, 26'h1);
        tick();
        chk("s_sig2", sig, 26'h3);
        tick();
        chk("s_sig3", sig, 26'h6);
        tick();
        chk("s_sig4", sig, 26'hD);
        chk("s_done", done, 1);
        tick();
        chk("s_pass", pass, 1);
        chk("s_sig_held", sig, 26'hD);

        // same response, wrong golden
        man = 26'h1;
        launch(60'h1, 26'hC);
        tick();
        man = '0;
        repeat (NPAT) tick();
        chk("s2_pass", pass, 0);
        chk("s2_sig", sig, 26'hD);
        mode = 0;

        // zero seed maps to 1
        launch(60'h0, 26'h0);
        for (int i = 0; i < NPAT; i++) begin
            chk($sformatf("zs_dutin%0d", i), dut_in, 64'h1 << i);
            tick();
        end
        chk("zs_done", done, 1);
        tick();

        // start while busy: ignored, one done at NPAT+1
        launch(60'h1, 26'h0);
        tick();
        seed  = 60'h5;
        start = 1'b1;
        chk("sb_dutin1", dut_in, 2);
        tick();
        start = 1'b0;
        chk("sb_dutin2", dut_in, 4);
        tick();
        chk("sb_dutin3", dut_in, 8);
        tick();
        chk("sb_done", done, 1);
        tick();
        chk("sb_done_once", done, 0);
        chk("sb_busy", busy, 0);
        tick();
        chk("sb_no_restart", busy, 0);

        // reset mid-run at pattern 2
        mode = 1;
        man  = 26'h3;
        launch(60'h1, 26'h0);
        tick();
        chk("rm_dutin", dut_in, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_dutin0", dut_in, 0);
        chk("rm_sig", sig, 0);
        chk("rm_pass", pass, 0);
        for (int i = 0; i < NPAT + 2; i++) begin
            tick();
            chk($sformatf("rm_nodone%0d", i), done, 0);
        end
        rst_n = 1'b1;
        mode  = 0;
        tick();
        launch(60'h1, 26'h0);
        for (int i = 0; i < NPAT; i++) begin
            chk($sformatf("rr_dutin%0d", i), dut_in, 64'h1 << i);
            tick();
        end
        chk("rr_done", done, 1);
        tick();
        chk("rr_pass", pass, 1);

        // stand-in benchmark, seed exercising LFSR feedback
        ml = 60'hC00_0000_0000_0001;
        mm = '0;
        for (int i = 0; i < NPAT; i++) begin
            mm = {mm[24:0], mm[25] ^ mm[5] ^ mm[1] ^ mm[0]} ^ bench_f(ml);
            ml = {ml[58:0], ml[59] ^ ml[58]};
        end
        mode = 2;
        launch(60'hC00_0000_0000_0001, mm);
        chk("i_dutin0", dut_in, 60'hC00_0000_0000_0001);
        tick();
        chk("i_dutin1", dut_in, 60'h800_0000_0000_0002);
        tick();
        chk("i_dutin2", dut_in, 60'h000_0000_0000_0005);
        repeat (NPAT - 2) tick();
        chk("i_done", done, 1);
        chk("i_sig", sig, mm);
        tick();
        chk("i_pass", pass, 1);

        // modified netlist, same golden
        mode = 3;
        launch(60'hC00_0000_0000_0001, mm);
        repeat (NPAT) tick();
        chk("t_done", done, 1);
        tick();
        chk("t_pass", pass, 0);
        mode = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
